// File: rtl/mm_bram_tiled_accum_dpath.sv
`default_nettype none
// ============================================================================
// Module      : mm_bram_tiled_accum_dpath
// Description : Row-tile by weight-column matrix-multiply datapath. Pipelined
//               multipliers and adder trees feed a per-row accumulator bank.
//               The last K-tile of a row emits one requantized row (shift,
//               optional saturation) to the result SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_bram_tiled_accum_dpath #(
  parameter int DATA_WIDTH = 8,
  parameter int TILE_LEN   = 4,
  parameter int COL_NUM    = 2,
  parameter int ROW_NUM    = 32,
  parameter int MAX_TILES  = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int SIGNED     = 0,
  localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM),
  localparam int TREE_LVL       = $clog2(TILE_LEN),
  localparam int ACC_WIDTH      = 2*DATA_WIDTH + $clog2(TILE_LEN*MAX_TILES) + 1,
  localparam int SHIFT_WIDTH    = $clog2(ACC_WIDTH)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  input  logic [DATA_WIDTH*TILE_LEN-1:0]          row_data_in,
  input  logic [DATA_WIDTH*TILE_LEN*COL_NUM-1:0]  weights,
  input  logic [ROW_ADDR_WIDTH-1:0]               in_row_addr,
  input  logic                                    in_first,
  input  logic                                    in_last,
  input  logic [SHIFT_WIDTH-1:0]                  cfg_shift,
  input  logic                                    cfg_sat_en,
  output logic [OUT_WIDTH*COL_NUM-1:0]            row_data_out,
  output logic [ROW_ADDR_WIDTH-1:0]               row_wraddr,
  output logic                                    row_wr_en,
  output logic                                    busy,
  output logic                                    sat_flag,
  output logic [15:0]                             out_count
);

  localparam int NPAD = 1 << TREE_LVL;   // tree leaves, padded to a power of two
  localparam int PW   = 2 * DATA_WIDTH;  // raw product width

  // Sideband that rides along with every beat.
  typedef struct packed {
    logic [ROW_ADDR_WIDTH-1:0] addr;
    logic                      first;
    logic                      last;
    logic [SHIFT_WIDTH-1:0]    shift;
    logic                      sat;
  } sb_t;

  // Stage S0: registered inputs
  logic                                   s0_valid_d, s0_valid_q;
  logic [DATA_WIDTH*TILE_LEN-1:0]         s0_row_d,   s0_row_q;
  logic [DATA_WIDTH*TILE_LEN*COL_NUM-1:0] s0_w_d,     s0_w_q;
  sb_t                                    s0_sb_d,    s0_sb_q;

  // Stage S1 (level 0, extended products) and tree levels 1..TREE_LVL
  logic [ACC_WIDTH-1:0] tree_d [0:TREE_LVL][0:COL_NUM-1][0:NPAD-1];
  logic [ACC_WIDTH-1:0] tree_q [0:TREE_LVL][0:COL_NUM-1][0:NPAD-1];
  logic [TREE_LVL:0]    v_d, v_q;
  sb_t                  sb_d [0:TREE_LVL];
  sb_t                  sb_q [0:TREE_LVL];

  // Accumulator bank (not reset; in_first defines the contents)
  logic [ACC_WIDTH-1:0] acc_q [0:ROW_NUM-1][0:COL_NUM-1];

  // Output register
  logic [OUT_WIDTH*COL_NUM-1:0] row_data_out_d, row_data_out_q;
  logic [ROW_ADDR_WIDTH-1:0]    row_wraddr_d,   row_wraddr_q;
  logic                         row_wr_en_d,    row_wr_en_q;
  logic                         sat_flag_d,     sat_flag_q;
  logic [15:0]                  out_count_d,    out_count_q;

  // Accumulate stage combinational signals
  logic                         sa_v;
  sb_t                          sa_sb;
  logic                         acc_we;
  logic [ACC_WIDTH*COL_NUM-1:0] acc_new_all;
  logic [OUT_WIDTH*COL_NUM-1:0] req_all;
  logic [COL_NUM-1:0]           ovf_all;

  assign sa_v   = v_q[TREE_LVL];
  assign sa_sb  = sb_q[TREE_LVL];
  assign acc_we = sa_v & ~reset;

  // Input capture, products, and one adder-tree level per stage
  always_comb begin
    logic [PW-1:0] pa;
    logic [PW-1:0] pb;
    logic [PW-1:0] prod;
    pa   = '0;
    pb   = '0;
    prod = '0;

    s0_valid_d    = in_valid;
    s0_row_d      = row_data_in;
    s0_w_d        = weights;
    s0_sb_d.addr  = in_row_addr;
    s0_sb_d.first = in_first;
    s0_sb_d.last  = in_last;
    s0_sb_d.shift = cfg_shift;
    s0_sb_d.sat   = cfg_sat_en;

    v_d[0]  = s0_valid_q;
    sb_d[0] = s0_sb_q;
    for (int l = 1; l <= TREE_LVL; l++) begin
      v_d[l]  = v_q[l-1];
      sb_d[l] = sb_q[l-1];
    end

    for (int l = 0; l <= TREE_LVL; l++) begin
      for (int j = 0; j < COL_NUM; j++) begin
        for (int k = 0; k < NPAD; k++) begin
          tree_d[l][j][k] = '0;
        end
      end
    end

    // Level 0: sign/zero-extended products; pad leaves stay zero.
    for (int j = 0; j < COL_NUM; j++) begin
      for (int i = 0; i < TILE_LEN; i++) begin
        if (SIGNED != 0) begin
          pa = PW'($signed(s0_row_q[i*DATA_WIDTH +: DATA_WIDTH]));
          pb = PW'($signed(s0_w_q[(i*COL_NUM+j)*DATA_WIDTH +: DATA_WIDTH]));
        end else begin
          pa = PW'(s0_row_q[i*DATA_WIDTH +: DATA_WIDTH]);
          pb = PW'(s0_w_q[(i*COL_NUM+j)*DATA_WIDTH +: DATA_WIDTH]);
        end
        prod = pa * pb;
        if (SIGNED != 0) begin
          tree_d[0][j][i] = ACC_WIDTH'($signed(prod));
        end else begin
          tree_d[0][j][i] = ACC_WIDTH'(prod);
        end
      end
    end

    // Levels 1..TREE_LVL: pairwise sums of the previous level.
    for (int l = 1; l <= TREE_LVL; l++) begin
      for (int j = 0; j < COL_NUM; j++) begin
        for (int k = 0; k < NPAD/2; k++) begin
          if (k < (NPAD >> l)) begin
            tree_d[l][j][k] = tree_q[l-1][j][2*k] + tree_q[l-1][j][2*k+1];
          end
        end
      end
    end
  end

  // Per-column accumulate and requantize
  for (genvar j = 0; j < COL_NUM; j++) begin : g_col
    logic [ACC_WIDTH-1:0] partial;
    logic [ACC_WIDTH-1:0] acc_rd;
    logic [ACC_WIDTH-1:0] acc_new;
    logic [ACC_WIDTH-1:0] shifted;
    logic [OUT_WIDTH-1:0] req;
    logic                 ovf;

    assign partial = tree_q[TREE_LVL][j][0];
    assign acc_rd  = acc_q[sa_sb.addr][j];
    assign acc_new = sa_sb.first ? partial : (acc_rd + partial);

    // Arithmetic shift for signed data, logical otherwise
    always_comb begin
      if (SIGNED != 0) begin
        shifted = ACC_WIDTH'($signed(acc_new) >>> sa_sb.shift);
      end else begin
        shifted = acc_new >> sa_sb.shift;
      end
    end

    if (OUT_WIDTH >= ACC_WIDTH) begin : g_wide
      // Output is wide enough to hold any accumulator value
      always_comb begin
        ovf = 1'b0;
        if (SIGNED != 0) begin
          req = OUT_WIDTH'($signed(shifted));
        end else begin
          req = OUT_WIDTH'(shifted);
        end
      end
    end else begin : g_narrow
      // Range check against OUT_WIDTH, clamp when saturation is enabled
      always_comb begin
        ovf = 1'b0;
        req = shifted[OUT_WIDTH-1:0];
        if (SIGNED != 0) begin
          ovf = ~(&shifted[ACC_WIDTH-1:OUT_WIDTH-1]) & (|shifted[ACC_WIDTH-1:OUT_WIDTH-1]);
          if (ovf && sa_sb.sat) begin
            req = shifted[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                       : {1'b0, {(OUT_WIDTH-1){1'b1}}};
          end
        end else begin
          ovf = |shifted[ACC_WIDTH-1:OUT_WIDTH];
          if (ovf && sa_sb.sat) begin
            req = {OUT_WIDTH{1'b1}};
          end
        end
      end
    end

    assign acc_new_all[j*ACC_WIDTH +: ACC_WIDTH] = acc_new;
    assign req_all[j*OUT_WIDTH +: OUT_WIDTH]     = req;
    assign ovf_all[j]                            = ovf;
  end

  // Output register next state: write only on the last tile of a row
  always_comb begin
    row_wr_en_d    = sa_v & sa_sb.last;
    row_wraddr_d   = row_wraddr_q;
    row_data_out_d = row_data_out_q;
    sat_flag_d     = sat_flag_q;
    out_count_d    = out_count_q;
    if (row_wr_en_d) begin
      row_wraddr_d   = sa_sb.addr;
      row_data_out_d = req_all;
      out_count_d    = out_count_q + 16'd1;
      if (sa_sb.sat && (|ovf_all)) begin
        sat_flag_d = 1'b1;
      end
    end
  end

  // Pipeline and output registers; valid bits and outputs cleared on reset
  always_ff @(posedge clk) begin
    s0_row_q <= s0_row_d;
    s0_w_q   <= s0_w_d;
    s0_sb_q  <= s0_sb_d;
    tree_q   <= tree_d;
    sb_q     <= sb_d;
    if (reset) begin
      s0_valid_q     <= 1'b0;
      v_q            <= '0;
      row_data_out_q <= '0;
      row_wraddr_q   <= '0;
      row_wr_en_q    <= 1'b0;
      sat_flag_q     <= 1'b0;
      out_count_q    <= '0;
    end else begin
      s0_valid_q     <= s0_valid_d;
      v_q            <= v_d;
      row_data_out_q <= row_data_out_d;
      row_wraddr_q   <= row_wraddr_d;
      row_wr_en_q    <= row_wr_en_d;
      sat_flag_q     <= sat_flag_d;
      out_count_q    <= out_count_d;
    end
  end

  // Accumulator bank write; the next beat's read sees this value
  always_ff @(posedge clk) begin
    if (acc_we) begin
      for (int j = 0; j < COL_NUM; j++) begin
        acc_q[sa_sb.addr][j] <= acc_new_all[j*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  assign row_data_out = row_data_out_q;
  assign row_wraddr   = row_wraddr_q;
  assign row_wr_en    = row_wr_en_q;
  assign sat_flag     = sat_flag_q;
  assign out_count    = out_count_q;
  assign busy         = s0_valid_q | (|v_q) | row_wr_en_q;

endmodule
`default_nettype wire

// File: tb/tb_mm_bram_tiled_accum_dpath.sv
`default_nettype none
// ============================================================================
// Module      : tb_mm_bram_tiled_accum_dpath
// Description : Scoreboard bench for mm_bram_tiled_accum_dpath: a default
//               (unsigned, 32-bit out) instance plus a signed 16-bit-out
//               instance for saturation behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_bram_tiled_accum_dpath;

  localparam int LAT = 5;

  logic        clk;
  logic        reset;

  // Default instance
  logic        in_valid;
  logic [31:0] row_data_in;
  logic [63:0] weights;
  logic [4:0]  in_row_addr;
  logic        in_first, in_last;
  logic [4:0]  cfg_shift;
  logic        cfg_sat_en;
  logic [63:0] row_data_out;
  logic [4:0]  row_wraddr;
  logic        row_wr_en, busy, sat_flag;
  logic [15:0] out_count;

  // Signed, 16-bit output instance
  logic        s_in_valid;
  logic [31:0] s_row_data_in;
  logic [63:0] s_weights;
  logic [4:0]  s_cfg_shift;
  logic        s_cfg_sat_en;
  logic [31:0] s_row_data_out;
  logic [4:0]  s_row_wraddr;
  logic        s_row_wr_en, s_busy, s_sat_flag;
  logic [15:0] s_out_count;

  mm_bram_tiled_accum_dpath u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .row_data_in(row_data_in),
    .weights(weights), .in_row_addr(in_row_addr), .in_first(in_first),
    .in_last(in_last), .cfg_shift(cfg_shift), .cfg_sat_en(cfg_sat_en),
    .row_data_out(row_data_out), .row_wraddr(row_wraddr), .row_wr_en(row_wr_en),
    .busy(busy), .sat_flag(sat_flag), .out_count(out_count)
  );

  mm_bram_tiled_accum_dpath #(.SIGNED(1), .OUT_WIDTH(16)) u_sat (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .row_data_in(s_row_data_in),
    .weights(s_weights), .in_row_addr(5'd0), .in_first(1'b1),
    .in_last(1'b1), .cfg_shift(s_cfg_shift), .cfg_sat_en(s_cfg_sat_en),
    .row_data_out(s_row_data_out), .row_wraddr(s_row_wraddr), .row_wr_en(s_row_wr_en),
    .busy(s_busy), .sat_flag(s_sat_flag), .out_count(s_out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard and reference model
  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
    int          due;
    int          cnt;
  } exp_t;

  exp_t        sb[$];
  logic [21:0] m_acc [0:31][0:1];
  logic [31:0] opened = '0;
  int          m_cnt = 0;

  function automatic logic [31:0] splat(input logic [7:0] v);
    return {4{v}};
  endfunction

  function automatic logic [63:0] mkw(input logic [31:0] c0, input logic [31:0] c1);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      w[i*16 +: 8]     = c0[i*8 +: 8];
      w[i*16 + 8 +: 8] = c1[i*8 +: 8];
    end
    return w;
  endfunction

  // Drive one beat; when tracked, update the model and queue the expected write
  task automatic beat(input logic [31:0] row, input logic [63:0] w, input logic [4:0] addr,
                      input logic first, input logic last, input logic [4:0] sh, input bit track);
    logic [21:0] p;
    logic [63:0] d;
    d = '0;
    @(negedge clk);
    in_valid    = 1'b1;
    row_data_in = row;
    weights     = w;
    in_row_addr = addr;
    in_first    = first;
    in_last     = last;
    cfg_shift   = sh;
    cfg_sat_en  = 1'b0;
    if (track) begin
      for (int j = 0; j < 2; j++) begin
        p = '0;
        for (int i = 0; i < 4; i++) begin
          p = p + 22'(row[i*8 +: 8]) * 22'(w[(i*2+j)*8 +: 8]);
        end
        m_acc[addr][j] = first ? p : (m_acc[addr][j] + p);
        d[j*32 +: 32]  = 32'(m_acc[addr][j] >> sh);
      end
      if (first) opened[addr] = 1'b1;
      if (last) begin
        m_cnt++;
        sb.push_back('{addr, d, cyc + LAT, m_cnt});
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  // Compare every result write against the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (row_wr_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_wr", 64'(row_wr_en), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wraddr",    64'(row_wraddr), 64'(e.addr));
        chk("col0",      64'(row_data_out[31:0]),  64'(e.data[31:0]));
        chk("col1",      64'(row_data_out[63:32]), 64'(e.data[63:32]));
        chk("wr_cycle",  64'(cyc), 64'(e.due));
        chk("out_count", 64'(out_count), 64'(e.cnt[15:0]));
      end
    end
  end

  // One single-tile beat into the signed instance, then check its result
  task automatic sat_run(input string tag, input logic [7:0] r, input logic [7:0] w,
                         input logic [4:0] sh, input logic en,
                         input logic [15:0] exp_v, input logic exp_flag);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    s_in_valid    = 1'b1;
    s_row_data_in = {4{r}};
    s_weights     = {8{w}};
    s_cfg_shift   = sh;
    s_cfg_sat_en  = en;
    @(negedge clk);
    s_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_row_wr_en) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    chk({tag, "_c0"},   64'(s_row_data_out[15:0]),  64'(exp_v));
    chk({tag, "_c1"},   64'(s_row_data_out[31:16]), 64'(exp_v));
    chk({tag, "_flag"}, 64'(s_sat_flag), 64'(exp_flag));
  endtask

  initial begin
    bit          seen;
    logic [4:0]  ra;
    logic        rf, rl;
    reset = 1'b1;
    in_valid = 1'b0; row_data_in = '0; weights = '0; in_row_addr = '0;
    in_first = 1'b0; in_last = 1'b0; cfg_shift = '0; cfg_sat_en = 1'b0;
    s_in_valid = 1'b0; s_row_data_in = '0; s_weights = '0;
    s_cfg_shift = '0; s_cfg_sat_en = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data",   row_data_out, 64'd0);
    chk("rst_addr",   64'(row_wraddr), 64'd0);
    chk("rst_wr_en",  64'(row_wr_en), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_sat",    64'(sat_flag), 64'd0);
    chk("rst_count",  64'(out_count), 64'd0);
    chk("rst_s_busy", 64'(s_busy), 64'd0);
    reset = 1'b0;

    // Single tile, addr 7: col0 = 10, col1 = 1
    beat({8'd4, 8'd3, 8'd2, 8'd1}, mkw(splat(8'd1), 32'h0000_0001), 5'd7, 1'b1, 1'b1, 5'd0, 1'b1);
    idle(1);
    drain("drain_single");

    // Two-tile accumulate to addr 3: 8 + 24 = 32, only the last tile writes
    beat(splat(8'd1), mkw(splat(8'd2), splat(8'd2)), 5'd3, 1'b1, 1'b0, 5'd0, 1'b1);
    beat(splat(8'd2), mkw(splat(8'd3), splat(8'd3)), 5'd3, 1'b0, 1'b1, 5'd0, 1'b1);
    idle(1);
    drain("drain_two_tile");

    // Interleaved rows, partial 5 each -> addr1 = 10 then addr2 = 10
    beat({8'd2, 8'd1, 8'd1, 8'd1}, mkw(splat(8'd1), splat(8'd1)), 5'd1, 1'b1, 1'b0, 5'd0, 1'b1);
    beat({8'd2, 8'd1, 8'd1, 8'd1}, mkw(splat(8'd1), splat(8'd1)), 5'd2, 1'b1, 1'b0, 5'd0, 1'b1);
    beat({8'd2, 8'd1, 8'd1, 8'd1}, mkw(splat(8'd1), splat(8'd1)), 5'd1, 1'b0, 1'b1, 5'd0, 1'b1);
    beat({8'd2, 8'd1, 8'd1, 8'd1}, mkw(splat(8'd1), splat(8'd1)), 5'd2, 1'b0, 1'b1, 5'd0, 1'b1);
    idle(1);
    drain("drain_interleave");

    // Bubbles: valid 1,0,0,1 -> two writes 3 cycles apart, busy drops after
    beat(splat(8'd3), mkw(splat(8'd5), splat(8'd7)), 5'd9,  1'b1, 1'b1, 5'd0, 1'b1);
    idle(2);
    beat(splat(8'd4), mkw(splat(8'd6), splat(8'd8)), 5'd10, 1'b1, 1'b1, 5'd0, 1'b1);
    idle(1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (row_wr_en && row_wraddr == 5'd10) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bubble_seen", 64'(seen), 64'd1);
    chk("busy_on_wr",  64'(busy), 64'd1);
    @(negedge clk);
    chk("busy_drop",   64'(busy), 64'd0);

    // Right shift on the unsigned instance
    beat(splat(8'd200), mkw(splat(8'd200), splat(8'd3)), 5'd4, 1'b1, 1'b1, 5'd3, 1'b1);
    idle(1);
    drain("drain_shift");

    // Random mix of rows, tile counts, shifts and bubbles
    for (int n = 0; n < 40; n++) begin
      ra = 5'(16 + $urandom_range(0, 3));
      rf = !opened[ra] || ($urandom_range(0, 3) == 0);
      rl = 1'($urandom_range(0, 1));
      beat($urandom, {$urandom, $urandom}, ra, rf, rl, 5'($urandom_range(0, 4)), 1'b1);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);
    drain("drain_random");

    // Reset mid-flight: three accepted beats must never write
    beat(splat(8'd1), mkw(splat(8'd1), splat(8'd1)), 5'd20, 1'b1, 1'b1, 5'd0, 1'b0);
    beat(splat(8'd2), mkw(splat(8'd1), splat(8'd1)), 5'd21, 1'b1, 1'b1, 5'd0, 1'b0);
    beat(splat(8'd3), mkw(splat(8'd1), splat(8'd1)), 5'd22, 1'b1, 1'b1, 5'd0, 1'b0);
    idle(1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_cnt = 0;
    chk("mid_rst_busy",  64'(busy), 64'd0);
    chk("mid_rst_sat",   64'(sat_flag), 64'd0);
    chk("mid_rst_count", 64'(out_count), 64'd0);
    chk("mid_rst_wr_en", 64'(row_wr_en), 64'd0);
    idle(10);

    // Counter restarts from zero after reset
    beat(splat(8'd5), mkw(splat(8'd5), splat(8'd1)), 5'd23, 1'b1, 1'b1, 5'd0, 1'b1);
    idle(1);
    drain("drain_post_rst");

    // Signed 16-bit output: truncate, clamp high, fits, clamp low
    sat_run("trunc",  8'd127,  8'd127, 5'd0, 1'b0, 16'hFC04, 1'b0);
    sat_run("sat_hi", 8'd127,  8'd127, 5'd0, 1'b1, 16'h7FFF, 1'b1);
    sat_run("neg_sh", 8'h80,   8'd127, 5'd2, 1'b1, 16'hC080, 1'b1);
    sat_run("sat_lo", 8'h80,   8'd127, 5'd0, 1'b1, 16'h8000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
